// File: rtl/sram_axi_pkg.sv
// Shared types and AXI constants for the SRAM-to-AXI3 bridge.
// Both the top and the write sequencer import this package.
package sram_axi_pkg;

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_SEND = 1'b1
   } ar_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_SEND = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   localparam logic [3:0] INST_ID_DEF = 4'd0;
   localparam logic [3:0] DATA_ID_DEF = 4'd1;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [7:0] LEN_SINGLE  = 8'd0;
   localparam logic [2:0] SIZE_W      = 3'd2;

   function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
      return {1'b0, sram_size};
   endfunction

endpackage

// File: rtl/bridge_wr_fsm.sv
// AW/W/B sequencing for data-side stores, plus the compare of the pending
// store address against a fetch address (word granularity).
module bridge_wr_fsm
   import sram_axi_pkg::*;
#(
   parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic [31:0] i_addr,
   input  logic [1:0]  i_size,
   input  logic [3:0]  i_wstrb,
   input  logic [31:0] i_wdata,
   input  logic [29:0] i_cmp_word,
   input  logic        i_awready,
   input  logic        i_wready,
   input  logic        i_bvalid,
   output logic        o_idle,
   output logic        o_done,
   output logic        o_addr_hit,
   output logic [3:0]  o_awid,
   output logic [31:0] o_awaddr,
   output logic [2:0]  o_awsize,
   output logic        o_awvalid,
   output logic [3:0]  o_wid,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic        o_wlast,
   output logic        o_wvalid,
   output logic        o_bready,
   output w_state_e    o_state
);

   w_state_e    r_state;
   w_state_e    w_state_next;
   logic        r_aw_pend;
   logic        r_w_pend;
   logic [31:0] r_awaddr;
   logic [2:0]  r_awsize;
   logic [3:0]  r_wstrb;
   logic [31:0] r_wdata;
   logic        w_start;

   assign w_start = i_start && (r_state == W_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= W_IDLE;
         r_aw_pend <= 1'b0;
         r_w_pend  <= 1'b0;
         r_awaddr  <= '0;
         r_awsize  <= SIZE_W;
         r_wstrb   <= '0;
         r_wdata   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_start) begin
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
            r_awaddr  <= i_addr;
            r_awsize  <= axi_size(i_size);
            r_wstrb   <= i_wstrb;
            r_wdata   <= i_wdata;
         end else if (r_state == W_SEND) begin
            // AW and W channels complete independently of each other
            if (i_awready) r_aw_pend <= 1'b0;
            if (i_wready)  r_w_pend  <= 1'b0;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         W_IDLE: if (w_start) w_state_next = W_SEND;
         W_SEND: if ((!r_aw_pend || i_awready) && (!r_w_pend || i_wready))
                    w_state_next = W_RESP;
         W_RESP: if (i_bvalid) w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   assign o_idle     = (r_state == W_IDLE);
   assign o_done     = (r_state == W_RESP) && i_bvalid;
   assign o_addr_hit = (r_state != W_IDLE) && (r_awaddr[31:2] == i_cmp_word);
   assign o_awid     = DATA_ID;
   assign o_awaddr   = r_awaddr;
   assign o_awsize   = r_awsize;
   assign o_awvalid  = (r_state == W_SEND) && r_aw_pend;
   assign o_wid      = DATA_ID;
   assign o_wdata    = r_wdata;
   assign o_wstrb    = r_wstrb;
   assign o_wlast    = 1'b1;
   assign o_wvalid   = (r_state == W_SEND) && r_w_pend;
   assign o_bready   = (r_state == W_RESP);
   assign o_state    = r_state;

endmodule

// File: rtl/sram_axi_bridge.sv
// Merges the core's instruction and data SRAM-like ports onto one AXI3 master.
// Read arbitration and rid routing live here; stores go through bridge_wr_fsm.
module sram_axi_bridge
   import sram_axi_pkg::*;
#(
   parameter logic [3:0] INST_ID = INST_ID_DEF,
   parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_inst_sram_req,
   input  logic [1:0]  i_inst_sram_size,
   input  logic [31:0] i_inst_sram_addr,
   output logic        o_inst_sram_addr_ok,
   output logic        o_inst_sram_data_ok,
   output logic [31:0] o_inst_sram_rdata,
   input  logic        i_data_sram_req,
   input  logic        i_data_sram_wr,
   input  logic [1:0]  i_data_sram_size,
   input  logic [3:0]  i_data_sram_wstrb,
   input  logic [31:0] i_data_sram_addr,
   input  logic [31:0] i_data_sram_wdata,
   output logic        o_data_sram_addr_ok,
   output logic        o_data_sram_data_ok,
   output logic [31:0] o_data_sram_rdata,
   output logic [3:0]  o_arid,
   output logic [31:0] o_araddr,
   output logic [7:0]  o_arlen,
   output logic [2:0]  o_arsize,
   output logic [1:0]  o_arburst,
   output logic [1:0]  o_arlock,
   output logic [3:0]  o_arcache,
   output logic [2:0]  o_arprot,
   output logic        o_arvalid,
   input  logic        i_arready,
   input  logic [3:0]  i_rid,
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_rresp,
   input  logic        i_rlast,
   input  logic        i_rvalid,
   output logic        o_rready,
   output logic [3:0]  o_awid,
   output logic [31:0] o_awaddr,
   output logic [7:0]  o_awlen,
   output logic [2:0]  o_awsize,
   output logic [1:0]  o_awburst,
   output logic [1:0]  o_awlock,
   output logic [3:0]  o_awcache,
   output logic [2:0]  o_awprot,
   output logic        o_awvalid,
   input  logic        i_awready,
   output logic [3:0]  o_wid,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   output logic        o_wlast,
   output logic        o_wvalid,
   input  logic        i_wready,
   input  logic [3:0]  i_bid,
   input  logic [1:0]  i_bresp,
   input  logic        i_bvalid,
   output logic        o_bready,
   output ar_state_e   o_dbg_ar_state,
   output w_state_e    o_dbg_w_state
);

   ar_state_e   r_ar_state;
   ar_state_e   w_ar_next;
   logic [3:0]  r_arid;
   logic [31:0] r_araddr;
   logic [2:0]  r_arsize;
   logic        r_inst_busy;
   logic        r_data_busy;

   logic        w_wr_idle;
   logic        w_wr_done;
   logic        w_addr_hit;
   logic        w_ar_free;
   logic        w_data_rd_ok;
   logic        w_data_wr_ok;
   logic        w_inst_ok;
   logic        w_r_fire;
   logic        w_inst_ret;
   logic        w_data_ret;
   logic        w_unused;

   assign w_unused = ^{i_rresp, i_rlast, i_bid, i_bresp, i_inst_sram_addr[1:0]};

   assign w_ar_free    = (r_ar_state == AR_IDLE);
   assign w_data_rd_ok = i_data_sram_req && !i_data_sram_wr && w_ar_free
                         && !r_data_busy && w_wr_idle;
   assign w_data_wr_ok = i_data_sram_req && i_data_sram_wr && w_wr_idle && !r_data_busy;
   // A fetch loses AR to a data read granted this cycle, and must not overtake
   // an in-flight store to the same word.
   assign w_inst_ok    = i_inst_sram_req && w_ar_free && !r_inst_busy
                         && !w_data_rd_ok && !w_addr_hit;

   assign o_inst_sram_addr_ok = w_inst_ok;
   assign o_data_sram_addr_ok = w_data_rd_ok || w_data_wr_ok;

   assign o_rready   = !reset;
   assign w_r_fire   = i_rvalid && o_rready;
   assign w_inst_ret = w_r_fire && (i_rid == INST_ID);
   assign w_data_ret = w_r_fire && (i_rid == DATA_ID);

   assign o_inst_sram_data_ok = w_inst_ret;
   assign o_inst_sram_rdata   = i_rdata;
   assign o_data_sram_data_ok = w_data_ret || w_wr_done;
   assign o_data_sram_rdata   = i_rdata;

   always_comb begin
      w_ar_next = r_ar_state;
      case (r_ar_state)
         AR_IDLE: if (w_data_rd_ok || w_inst_ok) w_ar_next = AR_SEND;
         AR_SEND: if (i_arready) w_ar_next = AR_IDLE;
         default: w_ar_next = AR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ar_state  <= AR_IDLE;
         r_arid      <= '0;
         r_araddr    <= '0;
         r_arsize    <= SIZE_W;
         r_inst_busy <= 1'b0;
         r_data_busy <= 1'b0;
      end else begin
         r_ar_state <= w_ar_next;
         if (w_data_rd_ok) begin
            r_arid   <= DATA_ID;
            r_araddr <= i_data_sram_addr;
            r_arsize <= axi_size(i_data_sram_size);
         end else if (w_inst_ok) begin
            r_arid   <= INST_ID;
            r_araddr <= i_inst_sram_addr;
            r_arsize <= axi_size(i_inst_sram_size);
         end
         // A new accept in the same cycle as a return keeps the slot busy
         if (w_inst_ok)
            r_inst_busy <= 1'b1;
         else if (w_inst_ret)
            r_inst_busy <= 1'b0;
         if (w_data_rd_ok || w_data_wr_ok)
            r_data_busy <= 1'b1;
         else if (w_data_ret || w_wr_done)
            r_data_busy <= 1'b0;
      end
   end

   assign o_arid    = r_arid;
   assign o_araddr  = r_araddr;
   assign o_arsize  = r_arsize;
   assign o_arlen   = LEN_SINGLE;
   assign o_arburst = BURST_INCR;
   assign o_arlock  = 2'd0;
   assign o_arcache = 4'd0;
   assign o_arprot  = 3'd0;
   assign o_arvalid = (r_ar_state == AR_SEND);

   assign o_awlen   = LEN_SINGLE;
   assign o_awburst = BURST_INCR;
   assign o_awlock  = 2'd0;
   assign o_awcache = 4'd0;
   assign o_awprot  = 3'd0;

   assign o_dbg_ar_state = r_ar_state;

   bridge_wr_fsm #(
      .DATA_ID (DATA_ID)
   ) u_wr_fsm (
      .clk        (clk),
      .reset      (reset),
      .i_start    (w_data_wr_ok),
      .i_addr     (i_data_sram_addr),
      .i_size     (i_data_sram_size),
      .i_wstrb    (i_data_sram_wstrb),
      .i_wdata    (i_data_sram_wdata),
      .i_cmp_word (i_inst_sram_addr[31:2]),
      .i_awready  (i_awready),
      .i_wready   (i_wready),
      .i_bvalid   (i_bvalid),
      .o_idle     (w_wr_idle),
      .o_done     (w_wr_done),
      .o_addr_hit (w_addr_hit),
      .o_awid     (o_awid),
      .o_awaddr   (o_awaddr),
      .o_awsize   (o_awsize),
      .o_awvalid  (o_awvalid),
      .o_wid      (o_wid),
      .o_wdata    (o_wdata),
      .o_wstrb    (o_wstrb),
      .o_wlast    (o_wlast),
      .o_wvalid   (o_wvalid),
      .o_bready   (o_bready),
      .o_state    (o_dbg_w_state)
   );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: table-driven single reads/writes, then
// hand-written sequences for arbitration, hazards, back-pressure and reset.
module tb_sram_axi_bridge;
   import sram_axi_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        inst_req, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic [3:0]  arid, awid, wid, rid, bid;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
   logic [3:0]  arcache, awcache, wstrb;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   ar_state_e   dbg_ar;
   w_state_e    dbg_w;

   sram_axi_bridge dut (
      .clk(clk), .reset(reset),
      .i_inst_sram_req(inst_req), .i_inst_sram_size(inst_size), .i_inst_sram_addr(inst_addr),
      .o_inst_sram_addr_ok(inst_addr_ok), .o_inst_sram_data_ok(inst_data_ok),
      .o_inst_sram_rdata(inst_rdata),
      .i_data_sram_req(data_req), .i_data_sram_wr(data_wr), .i_data_sram_size(data_size),
      .i_data_sram_wstrb(data_wstrb), .i_data_sram_addr(data_addr),
      .i_data_sram_wdata(data_wdata), .o_data_sram_addr_ok(data_addr_ok),
      .o_data_sram_data_ok(data_data_ok), .o_data_sram_rdata(data_rdata),
      .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
      .o_arburst(arburst), .o_arlock(arlock), .o_arcache(arcache), .o_arprot(arprot),
      .o_arvalid(arvalid), .i_arready(arready),
      .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid),
      .o_rready(rready),
      .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
      .o_awburst(awburst), .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot),
      .o_awvalid(awvalid), .i_awready(awready),
      .o_wid(wid), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid),
      .i_wready(wready),
      .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
      .o_dbg_ar_state(dbg_ar), .o_dbg_w_state(dbg_w)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      inst_req = 1'b0; inst_size = 2'd2; inst_addr = '0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = '0;
      data_addr = '0; data_wdata = '0;
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
      rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      bid = '0; bresp = '0; bvalid = 1'b0;
   endtask

   typedef struct {
      logic        is_data;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] rdata;
      logic [3:0]  exp_id;
      logic [2:0]  exp_size;
   } rd_vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [2:0]  exp_size;
   } wr_vec_t;

   rd_vec_t rd_vecs[4];
   wr_vec_t wr_vecs[3];

   initial begin
      rd_vecs[0] = '{1'b0, 32'h1c00_0000, 2'd2, 32'hdead_beef, 4'd0, 3'd2};
      rd_vecs[1] = '{1'b1, 32'h8000_0041, 2'd0, 32'h1122_3344, 4'd1, 3'd0};
      rd_vecs[2] = '{1'b0, 32'h1c00_0004, 2'd2, 32'h0bad_f00d, 4'd0, 3'd2};
      rd_vecs[3] = '{1'b1, 32'h0000_0102, 2'd1, 32'hcafe_0000, 4'd1, 3'd1};
      wr_vecs[0] = '{32'h8000_0000, 2'd2, 4'hf,    32'h1234_5678, 3'd2};
      wr_vecs[1] = '{32'h0000_0081, 2'd0, 4'b0010, 32'h0000_ab00, 3'd0};
      wr_vecs[2] = '{32'h0000_0102, 2'd1, 4'b1100, 32'hbeef_0000, 3'd1};

      idle_inputs();
      reset = 1'b1;
      next_cycle();
      settle();
      check("rst_rready_low", {31'd0, rready}, 32'd0);
      check("rst_arvalid", {31'd0, arvalid}, 32'd0);
      next_cycle();
      reset = 1'b0;
      settle();
      check("rst_awvalid", {31'd0, awvalid}, 32'd0);
      check("rst_wvalid", {31'd0, wvalid}, 32'd0);
      check("rst_bready", {31'd0, bready}, 32'd0);
      check("rst_rready_high", {31'd0, rready}, 32'd1);
      check("rst_ar_state", {31'd0, dbg_ar}, {31'd0, AR_IDLE});
      check("rst_w_state", {30'd0, dbg_w}, {30'd0, W_IDLE});
      next_cycle();

      // Single reads, one per vector
      for (int i = 0; i < 4; i++) begin
         if (rd_vecs[i].is_data) begin
            data_req = 1'b1; data_wr = 1'b0;
            data_addr = rd_vecs[i].addr; data_size = rd_vecs[i].size;
         end else begin
            inst_req = 1'b1; inst_addr = rd_vecs[i].addr; inst_size = rd_vecs[i].size;
         end
         settle();
         check($sformatf("rd%0d_addr_ok", i),
               {31'd0, rd_vecs[i].is_data ? data_addr_ok : inst_addr_ok}, 32'd1);
         next_cycle();
         inst_req = 1'b0; data_req = 1'b0;
         arready = 1'b1;
         settle();
         check($sformatf("rd%0d_arvalid", i), {31'd0, arvalid}, 32'd1);
         check($sformatf("rd%0d_araddr", i), araddr, rd_vecs[i].addr);
         check($sformatf("rd%0d_arid", i), {28'd0, arid}, {28'd0, rd_vecs[i].exp_id});
         check($sformatf("rd%0d_arsize", i), {29'd0, arsize}, {29'd0, rd_vecs[i].exp_size});
         check($sformatf("rd%0d_arlen_burst", i), {22'd0, arlen, arburst}, {22'd0, 8'd0, 2'b01});
         next_cycle();
         arready = 1'b0;
         rvalid = 1'b1; rid = rd_vecs[i].exp_id; rdata = rd_vecs[i].rdata;
         settle();
         check($sformatf("rd%0d_arvalid_drop", i), {31'd0, arvalid}, 32'd0);
         check($sformatf("rd%0d_inst_data_ok", i), {31'd0, inst_data_ok},
               {31'd0, !rd_vecs[i].is_data});
         check($sformatf("rd%0d_data_data_ok", i), {31'd0, data_data_ok},
               {31'd0, rd_vecs[i].is_data});
         check($sformatf("rd%0d_rdata", i),
               rd_vecs[i].is_data ? data_rdata : inst_rdata, rd_vecs[i].rdata);
         next_cycle();
         rvalid = 1'b0;
      end

      // Single writes, one per vector
      for (int i = 0; i < 3; i++) begin
         data_req = 1'b1; data_wr = 1'b1; data_addr = wr_vecs[i].addr;
         data_size = wr_vecs[i].size; data_wstrb = wr_vecs[i].wstrb;
         data_wdata = wr_vecs[i].wdata;
         settle();
         check($sformatf("wr%0d_addr_ok", i), {31'd0, data_addr_ok}, 32'd1);
         next_cycle();
         data_req = 1'b0; data_wr = 1'b0;
         awready = 1'b1; wready = 1'b1;
         settle();
         check($sformatf("wr%0d_valids", i), {30'd0, awvalid, wvalid}, 32'd3);
         check($sformatf("wr%0d_awaddr", i), awaddr, wr_vecs[i].addr);
         check($sformatf("wr%0d_awsize", i), {29'd0, awsize}, {29'd0, wr_vecs[i].exp_size});
         check($sformatf("wr%0d_wstrb", i), {28'd0, wstrb}, {28'd0, wr_vecs[i].wstrb});
         check($sformatf("wr%0d_wdata", i), wdata, wr_vecs[i].wdata);
         check($sformatf("wr%0d_ids_last", i), {23'd0, awid, wid, wlast}, {23'd0, 4'd1, 4'd1, 1'b1});
         next_cycle();
         awready = 1'b0; wready = 1'b0;
         bvalid = 1'b1; bid = 4'd1;
         settle();
         check($sformatf("wr%0d_valids_drop", i), {30'd0, awvalid, wvalid}, 32'd0);
         check($sformatf("wr%0d_bready", i), {31'd0, bready}, 32'd1);
         check($sformatf("wr%0d_data_ok", i), {31'd0, data_data_ok}, 32'd1);
         next_cycle();
         bvalid = 1'b0;
         settle();
         check($sformatf("wr%0d_bready_drop", i), {31'd0, bready}, 32'd0);
         next_cycle();
      end

      // Same-cycle fetch and data read: data read wins AR
      inst_req = 1'b1; inst_addr = 32'h1c00_0010; inst_size = 2'd2;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000; data_size = 2'd2;
      settle();
      check("arb_data_ok", {31'd0, data_addr_ok}, 32'd1);
      check("arb_inst_blocked", {31'd0, inst_addr_ok}, 32'd0);
      next_cycle();
      data_req = 1'b0; arready = 1'b1;
      settle();
      check("arb_first_arid", {28'd0, arid}, 32'd1);
      check("arb_first_araddr", araddr, 32'h0000_2000);
      check("arb_inst_held", {31'd0, inst_addr_ok}, 32'd0);
      next_cycle();
      arready = 1'b0;
      settle();
      check("arb_inst_now_ok", {31'd0, inst_addr_ok}, 32'd1);
      next_cycle();
      inst_req = 1'b0; arready = 1'b1;
      settle();
      check("arb_second_arid", {28'd0, arid}, 32'd0);
      check("arb_second_araddr", araddr, 32'h1c00_0010);
      next_cycle();
      arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h5555_aaaa;
      settle();
      check("arb_ret_data", {30'd0, data_data_ok, inst_data_ok}, 32'd2);
      next_cycle();
      rid = 4'd0; rdata = 32'h7777_0001;
      settle();
      check("arb_ret_inst", {30'd0, data_data_ok, inst_data_ok}, 32'd1);
      check("arb_ret_inst_rdata", inst_rdata, 32'h7777_0001);
      next_cycle();
      rvalid = 1'b0;

      // Store with split AW/W readiness: N accept, wready N+1, awready N+3, bvalid N+5
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80; data_size = 2'd1;
      data_wstrb = 4'b0011; data_wdata = 32'ha5a5_1234;
      settle();
      check("bp_accept", {31'd0, data_addr_ok}, 32'd1);
      next_cycle();
      data_req = 1'b0; wready = 1'b1;
      settle();
      check("bp_n1_valids", {30'd0, awvalid, wvalid}, 32'd3);
      check("bp_n1_wstrb", {28'd0, wstrb}, 32'h3);
      next_cycle();
      wready = 1'b0;
      settle();
      check("bp_n2_valids", {30'd0, awvalid, wvalid}, 32'd2);
      next_cycle();
      awready = 1'b1;
      settle();
      check("bp_n3_valids", {30'd0, awvalid, wvalid}, 32'd2);
      check("bp_n3_awaddr", awaddr, 32'h80);
      next_cycle();
      awready = 1'b0;
      settle();
      check("bp_n4_valids", {30'd0, awvalid, wvalid}, 32'd0);
      check("bp_n4_no_data_ok", {31'd0, data_data_ok}, 32'd0);
      check("bp_n4_w_state", {30'd0, dbg_w}, {30'd0, W_RESP});
      next_cycle();
      bvalid = 1'b1;
      settle();
      check("bp_n5_data_ok", {31'd0, data_data_ok}, 32'd1);
      next_cycle();
      bvalid = 1'b0;
      settle();
      check("bp_n6_data_ok_clear", {31'd0, data_data_ok}, 32'd0);
      next_cycle();

      // Pending store to 0x100 blocks a fetch to the same word only
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h100; data_size = 2'd2;
      data_wstrb = 4'hf; data_wdata = 32'h0000_0100;
      settle();
      check("haz_store_accept", {31'd0, data_addr_ok}, 32'd1);
      next_cycle();
      data_req = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h102;
      settle();
      check("haz_same_word_send", {31'd0, inst_addr_ok}, 32'd0);
      next_cycle();
      inst_addr = 32'h200;
      settle();
      check("haz_other_word_ok", {31'd0, inst_addr_ok}, 32'd1);
      next_cycle();
      inst_req = 1'b0; arready = 1'b1;
      settle();
      check("haz_other_araddr", araddr, 32'h200);
      next_cycle();
      arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_0200;
      settle();
      check("haz_other_data_ok", {31'd0, inst_data_ok}, 32'd1);
      next_cycle();
      rvalid = 1'b0;
      inst_req = 1'b1; inst_addr = 32'h102;
      awready = 1'b1; wready = 1'b1;
      settle();
      check("haz_same_word_send2", {31'd0, inst_addr_ok}, 32'd0);
      next_cycle();
      awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
      settle();
      check("haz_same_word_resp", {31'd0, inst_addr_ok}, 32'd0);
      check("haz_store_done", {31'd0, data_data_ok}, 32'd1);
      next_cycle();
      bvalid = 1'b0;
      settle();
      check("haz_released", {31'd0, inst_addr_ok}, 32'd1);
      next_cycle();
      inst_req = 1'b0; arready = 1'b1;
      settle();
      check("haz_released_araddr", araddr, 32'h102);
      next_cycle();
      arready = 1'b0; rvalid = 1'b1; rid = 4'd0;
      next_cycle();
      rvalid = 1'b0;

      // Second data request waits for the outstanding data read
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h300;
      settle();
      check("dd_first_accept", {31'd0, data_addr_ok}, 32'd1);
      next_cycle();
      data_addr = 32'h304; arready = 1'b1;
      settle();
      check("dd_blocked_arsend", {31'd0, data_addr_ok}, 32'd0);
      next_cycle();
      arready = 1'b0;
      settle();
      check("dd_blocked_busy", {31'd0, data_addr_ok}, 32'd0);
      next_cycle();
      rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_0300;
      settle();
      check("dd_ret_data_ok", {31'd0, data_data_ok}, 32'd1);
      check("dd_blocked_ret_cycle", {31'd0, data_addr_ok}, 32'd0);
      next_cycle();
      rvalid = 1'b0;
      settle();
      check("dd_second_accept", {31'd0, data_addr_ok}, 32'd1);
      next_cycle();
      data_req = 1'b0; arready = 1'b1;
      settle();
      check("dd_second_araddr", araddr, 32'h304);
      next_cycle();
      arready = 1'b0; rvalid = 1'b1; rid = 4'd1;
      settle();
      check("dd_second_data_ok", {31'd0, data_data_ok}, 32'd1);
      next_cycle();
      rvalid = 1'b0;

      // Reset while a store sits in W_SEND
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h40; data_wdata = 32'h1;
      next_cycle();
      data_req = 1'b0; data_wr = 1'b0;
      settle();
      check("rs_in_send", {30'd0, awvalid, wvalid}, 32'd3);
      reset = 1'b1;
      next_cycle();
      settle();
      check("rs_valids_cleared", {30'd0, awvalid, wvalid}, 32'd0);
      check("rs_rready_low", {31'd0, rready}, 32'd0);
      reset = 1'b0;
      next_cycle();
      inst_req = 1'b1; inst_addr = 32'h40;
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h40;
      settle();
      check("rs_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
      check("rs_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
      idle_inputs();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
